exe_mem_skid: RTL and testbench

Parametrised EX→MEM pipeline boundary for the riscv_core. It replaces the fixed-width stall-less flop stage with a 2-entry skid buffer and a valid/ready handshake. It supports synchronous flush and squashes writes to x0. Full throughput at 1 transfer per cycle with 1-cycle latency; in_ready_o is registered, so there is no combinational ready path from MEM back to EX.

---
 rtl/exe_mem_skid_pkg.sv | 21 ++
 rtl/exe_mem_payload_reg.sv | 27 ++
 rtl/exe_mem_skid.sv | 158 +++++++++++++++
 tb/tb_exe_mem_skid.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_mem_skid_pkg.sv
// Shared types and defaults for the EX->MEM skid boundary.
// Default widths for the payload fields and the occupancy encoding.
package exe_mem_skid_pkg;

    localparam int DEF_RADDR_W = 5;
    localparam int DEF_RDATA_W = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_MEMOP_W = 4;

    // Memory op "no operation" is all zeros at any width
    localparam logic [DEF_MEMOP_W-1:0] MEM_NOP = '0;

    // Occupancy of the two-entry buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/exe_mem_payload_reg.sv
// Width-generic payload register with load and clear-to-NOP.
// NOP payload is all zeros, so clearing is a plain zero load.
module exe_mem_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Reset/clear dominate a load
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            q_q <= '0;
        end else if (ld_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/exe_mem_skid.sv
// EX->MEM boundary: 2-entry skid buffer, registered ready, flush, x0 squash.
// Optional EXE_MEM_STATS_EN adds stall and full-cycle counters.
module exe_mem_skid
    import exe_mem_skid_pkg::*;
#(
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int RDATA_W = DEF_RDATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEMOP_W = DEF_MEMOP_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic               reg_we_i,
    input  logic [RDATA_W-1:0] reg_wdata_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  mem_data_i,
    input  logic               mem_we_i,
    input  logic [MEMOP_W-1:0] mem_op_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               reg_we_o,
    output logic [RDATA_W-1:0] reg_wdata_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_data_o,
    output logic               mem_we_o,
    output logic [MEMOP_W-1:0] mem_op_o
`ifdef EXE_MEM_STATS_EN
    ,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        full_cnt_o
`endif
);

    localparam int PW = RADDR_W + 1 + RDATA_W + ADDR_W + DATA_W + 1 + MEMOP_W;

    occ_e          state_q, state_d;
    logic          in_ready_q;
    logic          accept, fire;
    logic          out_ld, out_clr, out_from_skid;
    logic          skid_ld, skid_clr;
    logic [PW-1:0] in_pl, out_d, out_q, skid_q;

    assign out_valid_o = (state_q != OCC_EMPTY);
    assign in_ready_o  = in_ready_q;
    assign accept      = in_valid_i && in_ready_q;
    assign fire        = out_valid_o && out_ready_i;

    // Writes to x0 are dropped at capture time
    assign in_pl = {reg_waddr_i,
                    reg_we_i && (reg_waddr_i != '0),
                    reg_wdata_i, mem_addr_i, mem_data_i,
                    mem_we_i, mem_op_i};

    assign out_d = out_from_skid ? skid_q : in_pl;

    // Occupancy transitions and register load/clear controls
    always_comb begin
        state_d       = state_q;
        out_ld        = 1'b0;
        out_from_skid = 1'b0;
        skid_ld       = 1'b0;
        skid_clr      = 1'b0;
        if (flush_i) begin
            state_d  = OCC_EMPTY;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d = OCC_ONE;
                        out_ld  = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && fire) begin
                        out_ld = 1'b1;
                    end else if (accept) begin
                        state_d = OCC_FULL;
                        skid_ld = 1'b1;
                    end else if (fire) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (fire) begin
                        state_d       = OCC_ONE;
                        out_ld        = 1'b1;
                        out_from_skid = 1'b1;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        // An empty stage always shows a NOP payload
        out_clr = (state_d == OCC_EMPTY);
    end

    // Occupancy and registered ready
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != OCC_FULL);
        end
    end

    exe_mem_payload_reg #(.W(PW)) u_out_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (out_clr),
        .ld_i  (out_ld),
        .d_i   (out_d),
        .q_o   (out_q)
    );

    exe_mem_payload_reg #(.W(PW)) u_skid_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (skid_clr),
        .ld_i  (skid_ld),
        .d_i   (in_pl),
        .q_o   (skid_q)
    );

    assign {reg_waddr_o, reg_we_o, reg_wdata_o, mem_addr_o,
            mem_data_o, mem_we_o, mem_op_o} = out_q;

`ifdef EXE_MEM_STATS_EN
    logic [31:0] stall_cnt_q, full_cnt_q;

    // Stall and full-cycle counters, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            if (out_valid_o && !out_ready_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (state_q == OCC_FULL) begin
                full_cnt_q <= full_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign full_cnt_o  = full_cnt_q;
`endif

endmodule

// File: tb/tb_exe_mem_skid.sv
// Self-checking bench for exe_mem_skid: FIFO reference model plus
// directed literal checks; counter checks when EXE_MEM_STATS_EN is set.
module tb_exe_mem_skid;

    typedef struct packed {
        logic [4:0]  wa;
        logic        we;
        logic [31:0] wd;
        logic [31:0] ma;
        logic [31:0] md;
        logic        mwe;
        logic [3:0]  op;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [4:0]  reg_waddr_i, reg_waddr_o;
    logic        reg_we_i, reg_we_o;
    logic [31:0] reg_wdata_i, reg_wdata_o;
    logic [31:0] mem_addr_i, mem_addr_o;
    logic [31:0] mem_data_i, mem_data_o;
    logic        mem_we_i, mem_we_o;
    logic [3:0]  mem_op_i, mem_op_o;
    logic        out_valid, out_ready;
`ifdef EXE_MEM_STATS_EN
    logic [31:0] stall_cnt, full_cnt;
`endif

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    ent_t mq[$];
    ent_t act;
    bit   m_fire, m_acc;
    logic [31:0] m_stall = '0;
    logic [31:0] m_full  = '0;

    always #5 clk = ~clk;

    exe_mem_skid dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .reg_waddr_i (reg_waddr_i),
        .reg_we_i    (reg_we_i),
        .reg_wdata_i (reg_wdata_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_we_i    (mem_we_i),
        .mem_op_i    (mem_op_i),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o),
        .reg_wdata_o (reg_wdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_we_o    (mem_we_o),
        .mem_op_o    (mem_op_o)
`ifdef EXE_MEM_STATS_EN
        ,
        .stall_cnt_o (stall_cnt),
        .full_cnt_o  (full_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [255:0] a,
                       input logic [255:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference: ordered queue of accepted entries, checked then advanced
    always @(negedge clk) begin
        act = {reg_waddr_o, reg_we_o, reg_wdata_o, mem_addr_o,
               mem_data_o, mem_we_o, mem_op_o};
        if (chk_en) begin
            chk("out_valid", out_valid, mq.size() > 0);
            chk("in_ready", in_ready, mq.size() < 2);
            if (mq.size() > 0) chk("payload", act, mq[0]);
            else               chk("bubble", act, 0);
`ifdef EXE_MEM_STATS_EN
            chk("stall_cnt", stall_cnt, m_stall);
            chk("full_cnt", full_cnt, m_full);
`endif
        end
        if (rst) begin
            mq.delete();
            m_stall = '0;
            m_full  = '0;
        end else begin
            if (mq.size() > 0 && !out_ready) m_stall = m_stall + 1;
            if (mq.size() == 2) m_full = m_full + 1;
            m_fire = (mq.size() > 0) && out_ready;
            m_acc  = in_valid && (mq.size() < 2);
            if (m_fire) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (m_acc)
                mq.push_back('{wa: reg_waddr_i,
                               we: reg_we_i && (reg_waddr_i != 0),
                               wd: reg_wdata_i, ma: mem_addr_i,
                               md: mem_data_i, mwe: mem_we_i,
                               op: mem_op_i});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] wa,
                         input logic we, input logic [31:0] wd,
                         input logic mwe, input logic [3:0] op);
        in_valid    = v;
        reg_waddr_i = wa;
        reg_we_i    = we;
        reg_wdata_i = wd;
        mem_addr_i  = wd ^ 32'h1000_0000;
        mem_data_i  = ~wd;
        mem_we_i    = mwe;
        mem_op_i    = op;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0);
        cyc(); cyc();
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: idle after reset with random payload, valid low
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 5'($urandom), 1'b1, $urandom, 1'b1, 4'($urandom));
            out_ready = 1'($urandom);
            cyc();
        end
        chk("t1_valid", out_valid, 0);
        chk("t1_ready", in_ready, 1);
        chk("t1_op", mem_op_o, 0);
        chk("t1_we", reg_we_o, 0);

        // 2: back-to-back streaming
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(i + 1), 1'b1, 32'h10 + 32'(i), 1'b0, 4'h2);
            cyc();
            chk("t2_wdata", reg_wdata_o, 32'h10 + 32'(i));
            chk("t2_ready", in_ready, 1);
        end
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0);
        cyc();

        // 3: backpressure fills the skid, C waits
        out_ready = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 32'hAAAA_0001, 1'b1, 4'h1); cyc();
        drive(1'b1, 5'd4, 1'b1, 32'hBBBB_0002, 1'b0, 4'h3); cyc();
        chk("t3_full_ready", in_ready, 0);
        chk("t3_head", reg_wdata_o, 32'hAAAA_0001);
        drive(1'b1, 5'd6, 1'b1, 32'hCCCC_0003, 1'b1, 4'h5);
        cyc(); cyc();
        chk("t3_hold", reg_wdata_o, 32'hAAAA_0001);
        out_ready = 1'b1;
        cyc();
        chk("t3_b", reg_wdata_o, 32'hBBBB_0002);
        cyc();
        chk("t3_c", reg_wdata_o, 32'hCCCC_0003);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0);
        cyc();
        chk("t3_drain", out_valid, 0);

        // 4: x0 squash
        drive(1'b1, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'h2); cyc();
        chk("t4_x0_we", reg_we_o, 0);
        chk("t4_x0_wd", reg_wdata_o, 32'hDEAD_BEEF);
        drive(1'b1, 5'd5, 1'b1, 32'h0000_0055, 1'b0, 4'h2); cyc();
        chk("t4_x5_we", reg_we_o, 1);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0);
        cyc();

        // 5: flush in FULL with incoming entry
        out_ready = 1'b0;
        drive(1'b1, 5'd7, 1'b1, 32'h5555_0001, 1'b1, 4'h6); cyc();
        drive(1'b1, 5'd8, 1'b1, 32'h5555_0002, 1'b1, 4'h7); cyc();
        flush = 1'b1;
        drive(1'b1, 5'd9, 1'b1, 32'h5555_0003, 1'b1, 4'h8); cyc();
        flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0);
        chk("t5_valid", out_valid, 0);
        chk("t5_mwe", mem_we_o, 0);
        chk("t5_op", mem_op_o, 0);
        chk("t5_ready", in_ready, 1);
        out_ready = 1'b1;
        cyc(); cyc(); cyc();
        // flush in ONE drops the same-cycle accept
        drive(1'b1, 5'd10, 1'b1, 32'h6666_0001, 1'b1, 4'h1); cyc();
        flush = 1'b1;
        drive(1'b1, 5'd11, 1'b1, 32'h6666_0002, 1'b1, 4'h1); cyc();
        flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0);
        chk("t5b_valid", out_valid, 0);
        cyc(); cyc();

        // 6: reset while FULL with MEM ready
        out_ready = 1'b0;
        drive(1'b1, 5'd12, 1'b1, 32'h7777_0001, 1'b1, 4'h9); cyc();
        drive(1'b1, 5'd13, 1'b1, 32'h7777_0002, 1'b1, 4'hA); cyc();
        out_ready = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0);
        chk("t6_valid", out_valid, 0);
        chk("t6_ready", in_ready, 1);
        chk("t6_we", reg_we_o, 0);
        chk("t6_wd", reg_wdata_o, 0);
`ifdef EXE_MEM_STATS_EN
        chk("t6_stall0", stall_cnt, 0);
        chk("t6_full0", full_cnt, 0);
        out_ready = 1'b0;
        drive(1'b1, 5'd14, 1'b1, 32'h8888_0001, 1'b0, 4'h1); cyc();
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0);
        cyc(); cyc(); cyc();
        chk("t6_stall3", stall_cnt, 3);
        out_ready = 1'b1;
        cyc(); cyc();
`endif
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
